// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer: single-cycle ALU ops, iterative shift-add MUL, optional restoring DIV.
// Define ALU_EXEC_DIV_EN to compile in the divider; without it opcode 25 is treated as an illegal opcode.
module alu_exec_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ex,
    output logic         busy,
    output logic [W-1:0] res,
    output logic [W-1:0] res_hi,
    output logic         zf,
    output logic         cf,
    output logic         err
);
    localparam int CW = $clog2(W + 1);
    localparam int XW = W + 16;

    localparam logic [4:0] OP_ADD = 5'd8;
    localparam logic [4:0] OP_SUB = 5'd9;
    localparam logic [4:0] OP_AND = 5'd10;
    localparam logic [4:0] OP_OR  = 5'd11;
    localparam logic [4:0] OP_XOR = 5'd12;
    localparam logic [4:0] OP_NOT = 5'd13;
    localparam logic [4:0] OP_LSL = 5'd15;
    localparam logic [4:0] OP_LSR = 5'd16;
    localparam logic [4:0] OP_ASR = 5'd17;
    localparam logic [4:0] OP_INC = 5'd18;
    localparam logic [4:0] OP_DEC = 5'd19;
    localparam logic [4:0] OP_MUL = 5'd24;
`ifdef ALU_EXEC_DIV_EN
    localparam logic [4:0] OP_DIV = 5'd25;
`endif

    typedef enum logic [2:0] {IDLE, RUN1, ITER, DONE, HOLD} state_t;

    state_t        r_state;
    logic [4:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [CW-1:0] r_cnt;
    logic          r_ex;
    logic          r_busy;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_resHi;
    logic          r_zf;
    logic          r_cf;
    logic          r_err;

    logic [W:0]           w_sum;
    logic [W-1:0]         w_res;
    logic [W-1:0]         w_resHi;
    logic                 w_cf;
    logic                 w_err;
    logic [3:0]           w_sh;
    logic [XW-1:0]        w_lsl;
    logic [XW-1:0]        w_lsr;
    logic signed [XW-1:0] w_asr;
    logic [W:0]           w_mulSum;
    logic [W-1:0]         w_hiNext;
    logic [W-1:0]         w_loNext;
    logic                 w_toIter;
    logic                 w_unusedBits;

    // Shifts run in a field padded by 16 bits so the bit just past the result is the last one shifted out.
    assign w_sh  = r_b[3:0];
    assign w_lsl = {{16{1'b0}}, r_a} << w_sh;
    assign w_lsr = {r_a, 16'b0} >> w_sh;
    assign w_asr = $signed({r_a, 16'b0}) >>> w_sh;
    assign w_unusedBits = ^{op[5], w_lsl[XW-1:W+1], w_lsr[14:0], w_asr[14:0]};

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_resHi = '0;
        w_cf    = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b};
                w_res = w_sum[W-1:0];
                w_cf  = w_sum[W];
            end
            OP_SUB: begin
                w_sum = {1'b0, r_a} - {1'b0, r_b};
                w_res = w_sum[W-1:0];
                w_cf  = ~w_sum[W];
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOT: w_res = ~r_a;
            OP_LSL: begin
                w_res = w_lsl[W-1:0];
                w_cf  = w_lsl[W];
            end
            OP_LSR: begin
                w_res = w_lsr[XW-1:16];
                w_cf  = w_lsr[15];
            end
            OP_ASR: begin
                w_res = w_asr[XW-1:16];
                w_cf  = w_asr[15];
            end
            OP_INC: begin
                w_sum = {1'b0, r_a} + {{W{1'b0}}, 1'b1};
                w_res = w_sum[W-1:0];
                w_cf  = w_sum[W];
            end
            OP_DEC: begin
                w_sum = {1'b0, r_a} - {{W{1'b0}}, 1'b1};
                w_res = w_sum[W-1:0];
                w_cf  = ~w_sum[W];
            end
`ifdef ALU_EXEC_DIV_EN
            OP_DIV: begin
                w_res   = '1;
                w_resHi = r_a;
                w_err   = 1'b1;
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // One iteration step: r_hi/r_lo hold the partial product (MUL) or remainder/quotient (DIV).
    assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});

`ifdef ALU_EXEC_DIV_EN
    logic [W:0] w_remSh;
    logic [W:0] w_remSub;
    assign w_remSh  = {r_hi, r_lo[W-1]};
    assign w_remSub = w_remSh - {1'b0, r_b};
`endif

    always_comb begin
        w_hiNext = w_mulSum[W:1];
        w_loNext = {w_mulSum[0], r_lo[W-1:1]};
`ifdef ALU_EXEC_DIV_EN
        if (r_op == OP_DIV) begin
            if (!w_remSub[W]) begin
                w_hiNext = w_remSub[W-1:0];
                w_loNext = {r_lo[W-2:0], 1'b1};
            end else begin
                w_hiNext = w_remSh[W-1:0];
                w_loNext = {r_lo[W-2:0], 1'b0};
            end
        end
`endif
    end

`ifdef ALU_EXEC_DIV_EN
    assign w_toIter = (op[4:0] == OP_MUL) || ((op[4:0] == OP_DIV) && (b != '0));
`else
    assign w_toIter = (op[4:0] == OP_MUL);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_ex    <= 1'b0;
            r_busy  <= 1'b0;
            r_res   <= '0;
            r_resHi <= '0;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op[4:0];
                        r_a     <= a;
                        r_b     <= b;
                        r_hi    <= '0;
                        r_lo    <= a;
                        r_cnt   <= CW'(W);
                        r_busy  <= 1'b1;
                        r_state <= w_toIter ? ITER : RUN1;
                    end
                end
                RUN1: begin
                    r_res   <= w_res;
                    r_resHi <= w_resHi;
                    r_zf    <= (w_res == '0);
                    r_cf    <= w_cf;
                    r_err   <= w_err;
                    r_ex    <= 1'b1;
                    r_state <= DONE;
                end
                ITER: begin
                    if (r_cnt != '0) begin
                        r_hi  <= w_hiNext;
                        r_lo  <= w_loNext;
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_res   <= r_lo;
                        r_resHi <= r_hi;
                        r_zf    <= (r_lo == '0);
                        r_cf    <= (r_op == OP_MUL) && (r_hi != '0);
                        r_err   <= 1'b0;
                        r_ex    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ex    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= start ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ex     = r_ex;
    assign busy   = r_busy;
    assign res    = r_res;
    assign res_hi = r_resHi;
    assign zf     = r_zf;
    assign cf     = r_cf;
    assign err    = r_err;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq (W=16); expectations follow ALU_EXEC_DIV_EN if defined.
module tb_alu_exec_seq;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ex;
    logic         busy;
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         zf;
    logic         cf;
    logic         err;

    int testCount;
    int failCount;
    int exCycle;
    int extraEx;
    logic busyAll;

    alu_exec_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ex     (ex),
        .busy   (busy),
        .res    (res),
        .res_hi (res_hi),
        .zf     (zf),
        .cf     (cf),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Raises start with the operands, scrambles the inputs after acceptance, and finds the ex edge.
    task automatic applyStimulus(input logic [5:0] iOp, input logic [W-1:0] iA, input logic [W-1:0] iB,
                                 input int dropAfter);
        @(negedge clk);
        start = 1'b1;
        op    = iOp;
        a     = iA;
        b     = iB;
        @(posedge clk);
        #1;
        a       = ~iA;
        b       = ~iB;
        op      = 6'h3F;
        busyAll = busy;
        exCycle = -1;
        for (int k = 1; k <= 40; k++) begin
            if (exCycle < 0) begin
                if (k == dropAfter) start = 1'b0;
                @(posedge clk);
                #1;
                busyAll = busyAll & busy;
                if (ex) exCycle = k;
            end
        end
    endtask

    task automatic finishOp(input int holdCycles);
        extraEx = 0;
        for (int k = 0; k < holdCycles + 3; k++) begin
            if (k == holdCycles) start = 1'b0;
            @(posedge clk);
            #1;
            if (ex) extraEx++;
        end
    endtask

    task automatic checkOp(input string tag, input int expLat, input logic [31:0] expProd,
                           input logic [2:0] expFlags, input int holdCycles);
        checkOutput({tag, "_lat"}, exCycle, expLat);
        checkOutput({tag, "_res"}, {res_hi, res}, expProd);
        checkOutput({tag, "_flags"}, {29'b0, zf, cf, err}, {29'b0, expFlags});
        checkOutput({tag, "_busy"}, {31'b0, busyAll}, 32'd1);
        finishOp(holdCycles);
        checkOutput({tag, "_reex"}, extraEx, 32'd0);
        checkOutput({tag, "_idle"}, {30'b0, ex, busy}, 32'd0);
    endtask

    // Flag expectations are packed as {zf, cf, err}.
    initial begin
        testCount = 0;
        failCount = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_res", {res_hi, res}, 32'd0);
        checkOutput("reset_flags", {27'b0, ex, busy, zf, cf, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(6'h08, 16'hFFFF, 16'h0001, 0); checkOp("add_wrap", 1, 32'h0000_0000, 3'b110, 3);
        applyStimulus(6'h09, 16'h0005, 16'h0007, 1); checkOp("sub_borrow", 1, 32'h0000_FFFE, 3'b000, 0);
        applyStimulus(6'h09, 16'h0007, 16'h0005, 0); checkOp("sub_ok", 1, 32'h0000_0002, 3'b010, 0);
        applyStimulus(6'h2A, 16'hF0F0, 16'h0FF0, 0); checkOp("and_op5", 1, 32'h0000_00F0, 3'b000, 0);
        applyStimulus(6'h0B, 16'hF000, 16'h000F, 0); checkOp("or", 1, 32'h0000_F00F, 3'b000, 0);
        applyStimulus(6'h0C, 16'hAAAA, 16'hAAAA, 0); checkOp("xor_zero", 1, 32'h0000_0000, 3'b100, 0);
        applyStimulus(6'h0D, 16'h00FF, 16'h1234, 0); checkOp("not", 1, 32'h0000_FF00, 3'b000, 0);
        applyStimulus(6'h0F, 16'h8001, 16'h0011, 0); checkOp("lsl1", 1, 32'h0000_0002, 3'b010, 0);
        applyStimulus(6'h0F, 16'h1234, 16'h0000, 0); checkOp("lsl0", 1, 32'h0000_1234, 3'b000, 0);
        applyStimulus(6'h10, 16'h0003, 16'h0001, 0); checkOp("lsr1", 1, 32'h0000_0001, 3'b010, 0);
        applyStimulus(6'h10, 16'h8000, 16'h000F, 0); checkOp("lsr15", 1, 32'h0000_0001, 3'b000, 0);
        applyStimulus(6'h11, 16'h8001, 16'h0001, 0); checkOp("asr1", 1, 32'h0000_C000, 3'b010, 0);
        applyStimulus(6'h11, 16'h8000, 16'h000F, 0); checkOp("asr15", 1, 32'h0000_FFFF, 3'b000, 0);
        applyStimulus(6'h12, 16'hFFFF, 16'h0000, 0); checkOp("inc_wrap", 1, 32'h0000_0000, 3'b110, 0);
        applyStimulus(6'h13, 16'h0000, 16'h0000, 0); checkOp("dec_wrap", 1, 32'h0000_FFFF, 3'b000, 0);
        applyStimulus(6'h13, 16'h0005, 16'h0000, 0); checkOp("dec", 1, 32'h0000_0004, 3'b010, 0);
        applyStimulus(6'h1E, 16'h1234, 16'h5678, 0); checkOp("illegal30", 1, 32'h0000_0000, 3'b101, 0);
        applyStimulus(6'h0E, 16'h1234, 16'h5678, 0); checkOp("illegal14", 1, 32'h0000_0000, 3'b101, 0);

        applyStimulus(6'h18, 16'h1234, 16'h5678, 0); checkOp("mul", 17, 32'h0626_0060, 3'b010, 2);
        applyStimulus(6'h18, 16'h0003, 16'h0005, 2); checkOp("mul_drop", 17, 32'h0000_000F, 3'b000, 0);
        applyStimulus(6'h18, 16'h0000, 16'h1234, 0); checkOp("mul_zero", 17, 32'h0000_0000, 3'b100, 0);
`ifdef ALU_EXEC_DIV_EN
        applyStimulus(6'h19, 16'd1000, 16'd7, 0); checkOp("div", 17, {16'd6, 16'd142}, 3'b000, 0);
        applyStimulus(6'h19, 16'd5, 16'd0, 0); checkOp("div0", 1, {16'd5, 16'hFFFF}, 3'b001, 0);
`else
        applyStimulus(6'h19, 16'd1000, 16'd7, 0); checkOp("div_off", 1, 32'h0000_0000, 3'b101, 0);
        applyStimulus(6'h19, 16'd5, 16'd0, 0); checkOp("div0_off", 1, 32'h0000_0000, 3'b101, 0);
`endif
        applyStimulus(6'h18, 16'hFFFF, 16'hFFFF, 0); checkOp("mul_max", 17, 32'hFFFE_0001, 3'b010, 0);

        // Abort a MUL at E8 with outputs still holding the previous nonzero result.
        @(negedge clk);
        start = 1'b1;
        op    = 6'h18;
        a     = 16'h1234;
        b     = 16'h5678;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid_mul_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_res", {res_hi, res}, 32'd0);
        checkOutput("rst_flags", {27'b0, ex, busy, zf, cf, err}, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        extraEx = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (ex) extraEx++;
        end
        checkOutput("rst_noex", extraEx, 32'd0);
        applyStimulus(6'h08, 16'd2, 16'd3, 0); checkOp("add_after_rst", 1, 32'd5, 3'b000, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
